// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bundles the fetch port, load/store port and memory-side bus
//               of the shared single-port memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if;
  // instruction fetch port
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        if_stall;
  // load/store port
  logic        d_req;
  logic        d_wr;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        d_stall;
  // memory side
  logic        mem_en;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  // arbiter view
  modport slave (
    input  if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ack, if_stall, d_rdata, d_ack, d_stall,
           mem_en, mem_wr, mem_addr, mem_wdata
  );

  // requester / memory view
  modport master (
    output if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ack, if_stall, d_rdata, d_ack, d_stall,
           mem_en, mem_wr, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one fixed-latency single-port memory between
//               instruction fetch (I) and load/store (D). One access in
//               flight; D has priority but is capped at MAX_D_BURST
//               consecutive grants while a fetch is waiting.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int MEM_LAT     = 2,
  parameter int MAX_D_BURST = 4
) (
  input  wire logic    clk,
  input  wire logic    rst,   // asynchronous, active-low
  mem_arbiter_if.slave bus
);

  localparam int CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STREAK_W = $clog2(MAX_D_BURST + 1);
  localparam logic [CNT_W-1:0]    CNT_INIT   = CNT_W'(MEM_LAT - 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_BURST);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t                state_q,     state_d;
  logic [CNT_W-1:0]      cnt_q,       cnt_d;
  logic [STREAK_W-1:0]   d_streak_q,  d_streak_d;
  logic                  port_d_q,    port_d_d;     // 1 = D owns the access
  logic                  wr_q,        wr_d;
  logic [31:0]           mem_addr_q,  mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic [31:0]           if_rdata_q,  if_rdata_d;
  logic [31:0]           d_rdata_q,   d_rdata_d;

  logic streak_full;
  logic gnt_data;
  logic gnt_fetch;
  logic last_beat;

  assign streak_full = (d_streak_q == STREAK_MAX);
  assign last_beat   = (state_q == ST_ACCESS) && (cnt_q == '0);

  // Arbitration, access sequencing and read-data capture
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    d_streak_d  = d_streak_q;
    port_d_d    = port_d_q;
    wr_d        = wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    gnt_data    = 1'b0;
    gnt_fetch   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // D wins unless a waiting fetch has already seen a full D streak
        if (bus.d_req && !(bus.if_req && streak_full)) begin
          gnt_data = 1'b1;
        end else if (bus.if_req) begin
          gnt_fetch = 1'b1;
        end

        if (gnt_data) begin
          port_d_d    = 1'b1;
          wr_d        = bus.d_wr;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          cnt_d       = CNT_INIT;
          state_d     = ST_ACCESS;
          if (bus.if_req) begin
            if (!streak_full) begin
              d_streak_d = d_streak_q + 1'b1;
            end
          end else begin
            d_streak_d = '0;
          end
        end else if (gnt_fetch) begin
          // fetches carry no store data; mem_wdata keeps its last value
          port_d_d   = 1'b0;
          wr_d       = 1'b0;
          mem_addr_d = bus.if_addr;
          cnt_d      = CNT_INIT;
          state_d    = ST_ACCESS;
          d_streak_d = '0;
        end
      end

      ST_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
          if (!wr_q) begin
            if (port_d_q) begin
              d_rdata_d = bus.mem_rdata;
            end else begin
              if_rdata_d = bus.mem_rdata;
            end
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_RESP: begin
        // no grant here: the requester's req is still high this cycle
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset also kills any in-flight access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      d_streak_q  <= '0;
      port_d_q    <= 1'b0;
      wr_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      d_streak_q  <= d_streak_d;
      port_d_q    <= port_d_d;
      wr_q        <= wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // Outputs decode straight from state so reset drops them without a clock
  assign bus.mem_en    = (state_q == ST_ACCESS);
  assign bus.mem_wr    = last_beat && wr_q && port_d_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_ack    = (state_q == ST_RESP) && !port_d_q;
  assign bus.d_ack     = (state_q == ST_RESP) &&  port_d_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.if_stall  = bus.if_req && !bus.if_ack;
  assign bus.d_stall   = bus.d_req  && !bus.d_ack;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter. One instance
//               with MEM_LAT=2 covers fetch, load, store, contention,
//               starvation and reset; a second with MEM_LAT=1 covers
//               back-to-back fetches.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  mem_arbiter_if bus ();
  mem_arbiter_if bus1 ();

  // 10-unit clock
  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(2), .MAX_D_BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  mem_arbiter #(.MEM_LAT(1), .MAX_D_BURST(4)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  task automatic clear_inputs();
    bus.if_req  = 1'b0; bus.if_addr  = '0;
    bus.d_req   = 1'b0; bus.d_wr     = 1'b0;
    bus.d_addr  = '0;   bus.d_wdata  = '0;
    bus.mem_rdata  = '0;
    bus1.if_req = 1'b0; bus1.if_addr = '0;
    bus1.d_req  = 1'b0; bus1.d_wr    = 1'b0;
    bus1.d_addr = '0;   bus1.d_wdata = '0;
    bus1.mem_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.if_ack, bus.d_ack, bus.mem_en, bus.mem_wr, bus.if_stall, bus.d_stall} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {bus.if_ack, bus.d_ack, bus.mem_en, bus.mem_wr, bus.if_stall, bus.d_stall});
    end
    checks++;
    if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_membus: got addr=%h wdata=%h expected 0", bus.mem_addr, bus.mem_wdata);
    end
    checks++;
    if (bus.if_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_rdata: got if=%h d=%h expected 0", bus.if_rdata, bus.d_rdata);
    end
    checks++;
    if (bus1.mem_en !== 1'b0 || bus1.if_ack !== 1'b0) begin
      failures++;
      $display("FAIL reset_lat1: got en=%b ack=%b expected 0", bus1.mem_en, bus1.if_ack);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_fetch();
    int ack_at = -1;
    int en_cnt = 0;
    bit wr_seen = 1'b0;
    bit d_ack_seen = 1'b0;
    logic [31:0] rdata_ack = '0;
    bus.if_addr   = 32'h100;
    bus.mem_rdata = 32'hDEADBEEF;
    bus.if_req    = 1'b1;
    #1;
    checks++;
    if (bus.if_stall !== 1'b1) begin
      failures++;
      $display("FAIL fetch_stall: got %b expected 1", bus.if_stall);
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.mem_en) en_cnt++;
      if (bus.mem_wr) wr_seen = 1'b1;
      if (bus.d_ack)  d_ack_seen = 1'b1;
      if (bus.if_ack && ack_at < 0) begin
        ack_at    = k;
        rdata_ack = bus.if_rdata;
        bus.if_req = 1'b0;
      end
    end
    checks++;
    if (ack_at !== 3) begin
      failures++;
      $display("FAIL fetch_latency: got ack at %0d expected 3", ack_at);
    end
    checks++;
    if (rdata_ack !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL fetch_rdata: got %h expected deadbeef", rdata_ack);
    end
    checks++;
    if (wr_seen !== 1'b0 || d_ack_seen !== 1'b0) begin
      failures++;
      $display("FAIL fetch_no_wr: got wr=%b d_ack=%b expected 0 0", wr_seen, d_ack_seen);
    end
    checks++;
    if (en_cnt !== 2) begin
      failures++;
      $display("FAIL fetch_en_cycles: got %0d expected 2", en_cnt);
    end
  endtask

  task automatic test_store();
    int ack_at = -1;
    int wr_at = -1;
    int wr_cnt = 0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rdata_ack = 32'hFFFFFFFF;
    bus.d_wr      = 1'b1;
    bus.d_addr    = 32'h40;
    bus.d_wdata   = 32'h12345678;
    bus.mem_rdata = 32'hCAFEF00D;
    bus.d_req     = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        // requester changes its request mid-access; must be ignored
        bus.d_addr  = 32'h999;
        bus.d_wdata = 32'hFFFF0000;
      end
      if (bus.mem_wr) begin
        wr_cnt++;
        wr_at   = k;
        wr_addr = bus.mem_addr;
        wr_data = bus.mem_wdata;
      end
      if (bus.d_ack && ack_at < 0) begin
        ack_at    = k;
        rdata_ack = bus.d_rdata;
        bus.d_req = 1'b0;
        bus.d_wr  = 1'b0;
      end
    end
    checks++;
    if (wr_cnt !== 1 || wr_at !== 2) begin
      failures++;
      $display("FAIL store_wr_pulse: got count=%0d at=%0d expected 1 at 2", wr_cnt, wr_at);
    end
    checks++;
    if (wr_addr !== 32'h40 || wr_data !== 32'h12345678) begin
      failures++;
      $display("FAIL store_bus: got addr=%h data=%h expected 00000040 12345678", wr_addr, wr_data);
    end
    checks++;
    if (ack_at !== 3) begin
      failures++;
      $display("FAIL store_ack: got ack at %0d expected 3", ack_at);
    end
    checks++;
    if (rdata_ack !== 32'h0 || bus.if_rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL store_rdata_kept: got d=%h if=%h expected 00000000 deadbeef",
               rdata_ack, bus.if_rdata);
    end
  endtask

  task automatic test_load();
    int ack_at = -1;
    bit wr_seen = 1'b0;
    logic [31:0] rdata_ack = '0;
    bus.d_wr      = 1'b0;
    bus.d_addr    = 32'h80;
    bus.mem_rdata = 32'h0BADF00D;
    bus.d_req     = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.mem_wr) wr_seen = 1'b1;
      if (bus.d_ack && ack_at < 0) begin
        ack_at    = k;
        rdata_ack = bus.d_rdata;
        bus.d_req = 1'b0;
      end
    end
    checks++;
    if (ack_at !== 3 || rdata_ack !== 32'h0BADF00D) begin
      failures++;
      $display("FAIL load: got ack at %0d data=%h expected 3 0badf00d", ack_at, rdata_ack);
    end
    checks++;
    if (wr_seen !== 1'b0) begin
      failures++;
      $display("FAIL load_no_wr: got %b expected 0", wr_seen);
    end
  endtask

  task automatic test_drop_mid_access();
    int ack_at = -1;
    logic [31:0] addr_k2 = '0;
    logic [31:0] rdata_ack = '0;
    bus.if_addr   = 32'h700;
    bus.mem_rdata = 32'h55AA55AA;
    bus.if_req    = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.if_req  = 1'b0;
        bus.if_addr = 32'h123;
      end
      if (k == 2) addr_k2 = bus.mem_addr;
      if (bus.if_ack && ack_at < 0) begin
        ack_at    = k;
        rdata_ack = bus.if_rdata;
      end
    end
    checks++;
    if (ack_at !== 3 || rdata_ack !== 32'h55AA55AA) begin
      failures++;
      $display("FAIL drop_req: got ack at %0d data=%h expected 3 55aa55aa", ack_at, rdata_ack);
    end
    checks++;
    if (addr_k2 !== 32'h700) begin
      failures++;
      $display("FAIL drop_addr_stable: got %h expected 00000700", addr_k2);
    end
  endtask

  task automatic test_same_cycle();
    int d_ack_at = -1;
    int i_ack_at = -1;
    logic [31:0] addr_k5 = '0;
    logic if_stall_k3 = 1'b0;
    logic [31:0] d_rdata_ack = '0;
    bus.mem_rdata = 32'h11112222;
    bus.if_addr   = 32'h200;
    bus.d_addr    = 32'h300;
    bus.d_wr      = 1'b0;
    bus.if_req    = 1'b1;
    bus.d_req     = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 3) if_stall_k3 = bus.if_stall;
      if (k == 5) addr_k5 = bus.mem_addr;
      if (bus.d_ack && d_ack_at < 0) begin
        d_ack_at    = k;
        d_rdata_ack = bus.d_rdata;
        bus.d_req   = 1'b0;
      end
      if (bus.if_ack && i_ack_at < 0) begin
        i_ack_at   = k;
        bus.if_req = 1'b0;
      end
    end
    checks++;
    if (d_ack_at !== 3 || i_ack_at !== 7) begin
      failures++;
      $display("FAIL same_cycle_order: got d at %0d i at %0d expected 3 7", d_ack_at, i_ack_at);
    end
    checks++;
    if (addr_k5 !== 32'h200 || if_stall_k3 !== 1'b1) begin
      failures++;
      $display("FAIL same_cycle_i: got addr=%h stall=%b expected 00000200 1", addr_k5, if_stall_k3);
    end
    checks++;
    if (d_rdata_ack !== 32'h11112222) begin
      failures++;
      $display("FAIL same_cycle_drdata: got %h expected 11112222", d_rdata_ack);
    end
  endtask

  task automatic test_starvation();
    logic [6:0]  seq = '0;   // 1 = D ack, 0 = I ack, in completion order
    int          n = 0;
    logic [31:0] i_addr = '0;
    bus.if_addr = 32'h500;
    bus.d_addr  = 32'h600;
    bus.d_wr    = 1'b0;
    bus.if_req  = 1'b1;
    bus.d_req   = 1'b1;
    for (int k = 1; k <= 28; k++) begin
      @(negedge clk);
      if (bus.d_ack) begin
        if (n < 7) seq[n] = 1'b1;
        n++;
      end
      if (bus.if_ack) begin
        if (n < 7) seq[n] = 1'b0;
        i_addr = bus.mem_addr;
        n++;
      end
    end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (n !== 7 || seq !== 7'b110_1111) begin
      failures++;
      $display("FAIL starvation_order: got n=%0d seq=%b expected 7 1101111", n, seq);
    end
    checks++;
    if (i_addr !== 32'h500) begin
      failures++;
      $display("FAIL starvation_i_addr: got %h expected 00000500", i_addr);
    end
  endtask

  task automatic test_reset_mid_store();
    logic en_before;
    logic en_after;
    logic wr_after;
    bit   wr_seen = 1'b0;
    bit   en_seen = 1'b0;
    bit   ack_seen = 1'b0;
    bus.d_wr    = 1'b1;
    bus.d_addr  = 32'h44;
    bus.d_wdata = 32'hAAAA5555;
    bus.d_req   = 1'b1;
    @(negedge clk);
    en_before = bus.mem_en;
    rst = 1'b0;
    #1;
    en_after = bus.mem_en;
    wr_after = bus.mem_wr;
    bus.d_req = 1'b0;
    bus.d_wr  = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 3) rst = 1'b1;
      if (bus.mem_wr) wr_seen = 1'b1;
      if (bus.mem_en) en_seen = 1'b1;
      if (bus.d_ack)  ack_seen = 1'b1;
    end
    checks++;
    if (en_before !== 1'b1 || en_after !== 1'b0 || wr_after !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_drop: got before=%b en=%b wr=%b expected 1 0 0",
               en_before, en_after, wr_after);
    end
    checks++;
    if (wr_seen !== 1'b0 || en_seen !== 1'b0 || ack_seen !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_quiet: got wr=%b en=%b ack=%b expected 0 0 0",
               wr_seen, en_seen, ack_seen);
    end
    checks++;
    if (bus.mem_addr !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid_addr: got %h expected 00000000", bus.mem_addr);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ack_mask = '0;
    logic [15:0] en_mask  = '0;
    bit          data_ok  = 1'b1;
    bus1.if_addr   = 32'h10;
    bus1.mem_rdata = 32'h77;
    bus1.if_req    = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus1.if_ack) begin
        ack_mask[k] = 1'b1;
        if (bus1.if_rdata !== 32'h77) data_ok = 1'b0;
      end
      if (bus1.mem_en) en_mask[k] = 1'b1;
    end
    bus1.if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (ack_mask !== 16'h0924) begin
      failures++;
      $display("FAIL b2b_ack_cycles: got %h expected 0924", ack_mask);
    end
    checks++;
    if (en_mask !== 16'h0492) begin
      failures++;
      $display("FAIL b2b_en_cycles: got %h expected 0492", en_mask);
    end
    checks++;
    if (data_ok !== 1'b1) begin
      failures++;
      $display("FAIL b2b_rdata: got mismatching if_rdata expected 00000077");
    end
  endtask

  // Watchdog so the run always terminates
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  // Test sequence
  initial begin
    clear_inputs();
    test_reset();
    test_single_fetch();
    test_store();
    test_load();
    test_drop_mid_access();
    test_same_cycle();
    test_starvation();
    test_reset_mid_store();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
